// File: rtl/bfp_width_tracker.sv
// Block-floating-point width tracker.
// Watches every butterfly output written during one FFT stage and keeps the
// widest two's-complement magnitude seen. When the stage ends it publishes that
// width for the next stage's normaliser and adds the implied left shift to the
// frame's block exponent.
module bfp_width_tracker #(
    parameter int FFT_DW            = 16,
    parameter int FFT_MAX_BIT_WIDTH = 5,
    parameter int EXP_W             = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         frame_start,
    input  logic                         stage_start,
    input  logic                         sample_valid,
    input  logic [FFT_DW-1:0]            sample_re,
    input  logic [FFT_DW-1:0]            sample_im,
    input  logic                         stage_done,
    output logic                         width_valid,
    output logic [FFT_MAX_BIT_WIDTH-1:0] current_variable_bit_width,
    output logic [EXP_W-1:0]             block_exponent,
    output logic                         busy
);

    localparam int MBW     = FFT_MAX_BIT_WIDTH;
    localparam int SUM_W   = EXP_W + FFT_MAX_BIT_WIDTH + 1;
    localparam int EXP_MAX = (2 ** EXP_W) - 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DRAIN   = 2'd2,
        S_REPORT  = 2'd3
    } state_t;

    // Significant-bit count of a two's-complement value. The most negative
    // value (-1.0) needs the full word; other negatives are measured on ~x.
    function automatic logic [MBW-1:0] sample_width(input logic [FFT_DW-1:0] x);
        logic [FFT_DW-1:0] v;
        logic [MBW-1:0]    w;
        w = '0;
        if (x == {1'b1, {(FFT_DW-1){1'b0}}}) begin
            w = MBW'(FFT_DW);
        end else begin
            v = x[FFT_DW-1] ? ~x : x;
            for (int i = 0; i < FFT_DW; i++) begin
                if (v[i]) begin
                    w = MBW'(i + 1);
                end
            end
        end
        return w;
    endfunction

    state_t               state_q, state_d;
    logic                 drain_cnt_q, drain_cnt_d;
    logic                 p1_valid_q, p1_valid_d;
    logic [MBW-1:0]       p1_width_q, p1_width_d;
    logic [MBW-1:0]       run_max_q, run_max_d;
    logic [MBW-1:0]       width_q, width_d;
    logic                 width_valid_q, width_valid_d;
    logic [EXP_W-1:0]     exp_q, exp_d;

    logic [FFT_DW-1:0]    lane_data [2];
    logic [MBW-1:0]       lane_width [2];
    logic [MBW-1:0]       sample_w;
    logic [MBW-1:0]       shift;
    logic [EXP_W-1:0]     exp_base;
    logic [SUM_W-1:0]     exp_sum;

    assign lane_data[0] = sample_re;
    assign lane_data[1] = sample_im;

    // One width detector per component of the complex sample.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            assign lane_width[gi] = sample_width(lane_data[gi]);
        end
    endgenerate

    assign sample_w = (lane_width[0] > lane_width[1]) ? lane_width[0] : lane_width[1];

    // Shift implied by the finished stage's width, and the saturating exponent
    // sum. A frame clear in the same cycle zeroes the base before adding.
    always_comb begin
        shift = '0;
        if (run_max_q != '0 && run_max_q != MBW'(FFT_DW - 1) && run_max_q != MBW'(FFT_DW)) begin
            shift = MBW'(FFT_DW - 1) - run_max_q;
        end
        exp_base = frame_start ? '0 : exp_q;
        exp_sum  = SUM_W'(exp_base) + SUM_W'(shift);
    end

    // Next-state logic: stage FSM, P1 width capture, P2 running max, report.
    always_comb begin
        state_d       = state_q;
        drain_cnt_d   = drain_cnt_q;
        p1_valid_d    = 1'b0;
        p1_width_d    = p1_width_q;
        run_max_d     = run_max_q;
        width_d       = width_q;
        width_valid_d = 1'b0;
        exp_d         = exp_base;

        if (p1_valid_q && (p1_width_q > run_max_q)) begin
            run_max_d = p1_width_q;
        end

        case (state_q)
            S_IDLE: begin
                if (stage_start) begin
                    state_d   = S_COLLECT;
                    run_max_d = '0;
                end
            end
            S_COLLECT: begin
                if (stage_start) begin
                    run_max_d = '0;
                end else begin
                    if (sample_valid) begin
                        p1_valid_d = 1'b1;
                        p1_width_d = sample_w;
                    end
                    if (stage_done) begin
                        state_d     = S_DRAIN;
                        drain_cnt_d = 1'b0;
                    end
                end
            end
            S_DRAIN: begin
                if (stage_start) begin
                    state_d   = S_COLLECT;
                    run_max_d = '0;
                end else if (drain_cnt_q) begin
                    // Pipeline is flushed: publish so outputs show in REPORT.
                    state_d       = S_REPORT;
                    width_d       = run_max_q;
                    width_valid_d = 1'b1;
                    exp_d         = (exp_sum > SUM_W'(EXP_MAX)) ? '1 : exp_sum[EXP_W-1:0];
                end else begin
                    drain_cnt_d = 1'b1;
                end
            end
            S_REPORT: begin
                if (stage_start) begin
                    state_d   = S_COLLECT;
                    run_max_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous reset; reset discards any partial stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            drain_cnt_q   <= 1'b0;
            p1_valid_q    <= 1'b0;
            p1_width_q    <= '0;
            run_max_q     <= '0;
            width_q       <= '0;
            width_valid_q <= 1'b0;
            exp_q         <= '0;
        end else begin
            state_q       <= state_d;
            drain_cnt_q   <= drain_cnt_d;
            p1_valid_q    <= p1_valid_d;
            p1_width_q    <= p1_width_d;
            run_max_q     <= run_max_d;
            width_q       <= width_d;
            width_valid_q <= width_valid_d;
            exp_q         <= exp_d;
        end
    end

    assign width_valid                = width_valid_q;
    assign current_variable_bit_width = width_q;
    assign block_exponent             = exp_q;
    assign busy                       = (state_q != S_IDLE);

endmodule
